pll_reset_sequencer: RTL
========================

Name: pll_reset_sequencer

Overview:
- Consumer-side companion to the pixel PLL wrapper; runs on the 50 MHz reference clock.
- Drives the PLL reset and monitors the asynchronous `locked` output.
- Releases the system reset only after lock has been stable for a programmable interval.
- Re-pulses the PLL on lock timeout or lock loss, and reports a hard fault after repeated failures.

Parameters:
- RST_PULSE_CYCLES, 16: refclk cycles `pll_rst` is held high per attempt (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before release (≥1).
- LOCK_TIMEOUT_CYCLES, 50000: cycles to wait for lock after a PLL reset pulse, 1 ms at 50 MHz (≥1).
- MAX_RETRIES, 7: failed lock attempts before entering FAIL (1..255).

Ports:
- refclk, input, 1: 50 MHz reference clock; the only clock.
- rst, input, 1: asynchronous, active-high reset.
- pll_locked, input, 1: PLL `locked`; asynchronous to refclk.
- retry_req, input, 1: one-cycle pulse; leaves FAIL and restarts sequencing.
- pll_rst, output, 1: reset to the PLL `rst` input.
- sys_rst, output, 1: registered reset for downstream logic; consumers resynchronize it into the pixel domain.
- ready, output, 1: high only in RUN.
- fail, output, 1: high only in FAIL.
- retry_count, output, 8: failed attempts since the last RUN, retry_req or rst.
- lost_count, output, 8: lock-loss events seen while in RUN; saturates at 255.

Behaviour:
- Reset (async assert, sync release on refclk):
  - state = PLL_RST, counters = 0.
  - pll_rst = 1, sys_rst = 1, ready = 0, fail = 0, retry_count = 0, lost_count = 0.
- Synchronization:
  - pll_locked passes through a 2-flop synchronizer to form locked_s; no other logic samples pll_locked.
  - All outputs are registered.
- One shared cycle counter `cnt`:
  - Width is clog2 of max(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES) + 1.
  - Cleared on every state transition.
- States and transitions:
  - PLL_RST:
    - Outputs: pll_rst = 1, sys_rst = 1.
    - When cnt == RST_PULSE_CYCLES-1, go to WAIT_LOCK.
    - pll_rst is therefore high for exactly RST_PULSE_CYCLES cycles.
  - WAIT_LOCK:
    - Outputs: pll_rst = 0, sys_rst = 1.
    - If locked_s, go to STABLE.
    - Else if cnt == LOCK_TIMEOUT_CYCLES-1, a timeout occurs:
      - If retry_count+1 ≥ MAX_RETRIES, set retry_count = MAX_RETRIES and go to FAIL.
      - Otherwise increment retry_count and go to PLL_RST.
    - If locked_s rises in the same cycle as the timeout, lock wins.
  - STABLE:
    - Outputs: pll_rst = 0, sys_rst = 1.
    - If !locked_s, go to WAIT_LOCK; cnt restarts and the timeout is re-armed, with no retry counted.
    - Else if cnt == LOCK_STABLE_CYCLES-1, go to RUN and clear retry_count.
  - RUN:
    - Outputs: pll_rst = 0, sys_rst = 0, ready = 1.
    - If !locked_s, go to PLL_RST and increment lost_count (saturating).
    - sys_rst rises on the same edge as the state change, 3 refclk edges after pll_locked falls (2 sync + 1).
  - FAIL:
    - Outputs: pll_rst = 0, sys_rst = 1, fail = 1.
    - pll_locked is ignored.
    - retry_req clears retry_count and goes to PLL_RST.
- Simultaneous events:
  - retry_req outside FAIL is ignored.
  - rst overrides everything.
- Glitch filter: a lock glitch shorter than 1 refclk may be missed; a glitch ≥ 2 cycles is always caught.
- Release latency: from a steady pll_locked rising edge in WAIT_LOCK to sys_rst falling is 2 + 1 + LOCK_STABLE_CYCLES refclk edges.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum {PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL}, 3-bit;
  - SYNC_STAGES = 2;
  - counter-width function.
- One sub-module, sync_2ff: generic single-bit 2-flop synchronizer, async active-high reset to 0.
- The FSM and counters live in the top module.

Test Plan (RST_PULSE_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=20, MAX_RETRIES=2):
- Normal bring-up: release rst; pll_locked rises 10 cycles after pll_rst falls.
  - Required: pll_rst high exactly 4 cycles; sys_rst falls 11 edges after pll_locked rises; ready = 1; retry_count = 0.
- Lock loss: after RUN, drop pll_locked for 3 cycles.
  - Required: sys_rst = 1 on edge 3; ready = 0; lost_count = 1; pll_rst pulses 4 cycles; re-release follows the bring-up timing.
- Timeout to FAIL: hold pll_locked = 0.
  - Required: first timeout gives retry_count = 1 and a new pll_rst pulse; second timeout gives retry_count = 2 and fail = 1; pll_rst stays 0 afterwards.
- Retry from FAIL: pulse retry_req for 1 cycle, then assert pll_locked.
  - Required: retry_count = 0, fail = 0, pll_rst pulses 4 cycles, then RUN.
- Unstable lock: in STABLE, drop pll_locked at cnt = 5 for 2 cycles.
  - Required: return to WAIT_LOCK; sys_rst stays 1; retry_count unchanged; the stable count restarts from 0.
- Async reset mid-RUN: assert rst between edges.
  - Required: sys_rst = 1 and pll_rst = 1 immediately; lost_count = 0; after rst release the full sequence repeats.

Source files
------------

// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;

  localparam int SYNC_STAGES = 2;

  // One spare bit keeps every terminal value representable without wrap.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit flop-chain synchronizer; clears to 0 on reset.
module sync_2ff
  import pll_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Pulses the PLL reset, qualifies lock over a stable window and then
// releases the downstream system reset; retries and faults on timeouts.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PLL_RST   | pll_rst held high for RST_PULSE_CYCLES
// WAIT_LOCK | waiting for synchronized lock, timeout armed
// STABLE    | lock seen, counting LOCK_STABLE_CYCLES consecutive cycles
// RUN       | sys_rst released, watching for lock loss
// FAIL      | retries exhausted, waiting for retry_req
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 7
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       retry_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] retry_count,
  output logic [7:0] lost_count
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam logic [CW-1:0] RST_LAST     = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    RETRY_MAX    = 8'(MAX_RETRIES);

  logic locked_s;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    retry_q, retry_d;
  logic [7:0]    lost_q, lost_d;
  logic          pll_rst_q, pll_rst_d;
  logic          sys_rst_q, sys_rst_d;
  logic          ready_q, ready_d;
  logic          fail_q, fail_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (locked_s) begin
          state_d = STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          if (retry_q >= RETRY_MAX - 8'd1) begin
            retry_d = RETRY_MAX;
            state_d = FAIL;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = PLL_RST;
          end
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          retry_d = 8'd0;
        end
      end
      RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d = PLL_RST;
          if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
        end
      end
      FAIL: begin
        cnt_d = cnt_q;
        if (retry_req) begin
          retry_d = 8'd0;
          state_d = PLL_RST;
        end
      end
      default: state_d = PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;

    // Outputs decode the next state so they change on the transition edge.
    pll_rst_d = (state_d == PLL_RST);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fail_d    = (state_d == FAIL);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= PLL_RST;
      cnt_q     <= '0;
      retry_q   <= 8'd0;
      lost_q    <= 8'd0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      lost_q    <= lost_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      ready_q   <= ready_d;
      fail_q    <= fail_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
  assign lost_count  = lost_q;

endmodule
